// File: rtl/qcl_add_sub_arbiter.sv
// Round-robin arbiter sharing one unsigned add/sub datapath among els_p requesters,
// with a fixed latency_p-deep result pipeline tagged by requester id.
module qcl_add_sub_arbiter #(
  parameter int unsigned width_p   = 8,
  parameter int unsigned els_p     = 4,
  parameter int unsigned latency_p = 1,
  localparam int unsigned id_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       en_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p-1:0]           sub_i,
  input  logic [els_p*width_p-1:0]   a_i,
  input  logic [els_p*width_p-1:0]   b_i,
  output logic [els_p-1:0]           ready_o,
  output logic                       v_o,
  output logic [id_width_lp-1:0]     id_o,
  output logic [width_p-1:0]         s_o,
  output logic                       c_o,
  output logic                       busy_o
);

  if (latency_p > 2 || els_p < 2 || els_p > 16 || width_p < 1 || width_p > 48) begin : g_bad_params
    $fatal(1, "qcl_add_sub_arbiter: unsupported parameter combination");
  end

  localparam int unsigned idx_w_lp = id_width_lp + 1;
  localparam logic [id_width_lp-1:0] last_id_lp = id_width_lp'(els_p - 1);

  typedef struct packed {
    logic                   v;
    logic [id_width_lp-1:0] id;
    logic                   c;
    logic [width_p-1:0]     s;
  } result_t;

  logic [id_width_lp-1:0] ptr_q;
  logic [id_width_lp-1:0] win;
  logic [id_width_lp-1:0] cand;
  logic [idx_w_lp-1:0]    idx_w;
  logic                   found;
  logic                   grant;
  logic [width_p-1:0]     a_arr [els_p];
  logic [width_p-1:0]     b_arr [els_p];
  logic [width_p:0]       res;
  result_t                issue;
  result_t                out;
  result_t                hold_q;

  for (genvar g = 0; g < els_p; g++) begin : g_unpack
    assign a_arr[g] = a_i[g*width_p +: width_p];
    assign b_arr[g] = b_i[g*width_p +: width_p];
  end

  // Scan ptr, ptr+1, ... (mod els_p) and take the first requester found.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_w = '0;
    cand  = '0;
    for (int unsigned k = 0; k < els_p; k++) begin
      idx_w = {1'b0, ptr_q} + idx_w_lp'(k);
      if (idx_w >= idx_w_lp'(els_p)) idx_w = idx_w - idx_w_lp'(els_p);
      cand = idx_w[id_width_lp-1:0];
      if (!found && v_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign grant   = found & en_i & ~reset_i;
  assign ready_o = grant ? (els_p'(1) << win) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else if (grant) begin
      ptr_q <= (win == last_id_lp) ? '0 : win + id_width_lp'(1);
    end
  end

  always_comb begin
    if (sub_i[win]) res = {1'b0, a_arr[win]} - {1'b0, b_arr[win]};
    else            res = {1'b0, a_arr[win]} + {1'b0, b_arr[win]};
    issue    = '0;
    issue.v  = grant;
    issue.id = win;
    issue.c  = res[width_p];
    issue.s  = res[width_p-1:0];
  end

  if (latency_p == 0) begin : g_comb
    assign out    = issue;
    assign busy_o = 1'b0;
  end else begin : g_pipe
    result_t stage_q [latency_p];
    logic    busy;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int unsigned i = 0; i < latency_p; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= issue;
        for (int unsigned i = 1; i < latency_p; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    always_comb begin
      busy = 1'b0;
      for (int unsigned i = 0; i < latency_p; i++) busy = busy | stage_q[i].v;
    end

    assign busy_o = busy;
    assign out    = stage_q[latency_p-1];
  end

  // Result fields stay on the last delivered op while no result is valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_q <= '0;
    end else if (out.v) begin
      hold_q <= out;
    end
  end

  assign v_o  = out.v;
  assign id_o = out.v ? out.id : hold_q.id;
  assign s_o  = out.v ? out.s  : hold_q.s;
  assign c_o  = out.v ? out.c  : hold_q.c;

endmodule

// File: tb/tb_qcl_add_sub_arbiter.sv
// Bench for qcl_add_sub_arbiter: latency 0/1/2 instances share one stimulus stream and are
// checked against a per-cycle grant history model, directed vectors and corner sequences.
module tb_qcl_add_sub_arbiter;
  localparam int W    = 8;
  localparam int N    = 4;
  localparam int NL   = 3;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           en;
  logic [N-1:0]   v;
  logic [N-1:0]   sub;
  logic [N*W-1:0] a;
  logic [N*W-1:0] b;

  logic [N-1:0] rdy  [NL];
  logic         vo   [NL];
  logic [1:0]   ido  [NL];
  logic [W-1:0] so   [NL];
  logic         co   [NL];
  logic         busy [NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    qcl_add_sub_arbiter #(
      .width_p  (W),
      .els_p    (N),
      .latency_p(g)
    ) u_dut (
      .clk_i  (clk),
      .reset_i(reset),
      .en_i   (en),
      .v_i    (v),
      .sub_i  (sub),
      .a_i    (a),
      .b_i    (b),
      .ready_o(rdy[g]),
      .v_o    (vo[g]),
      .id_o   (ido[g]),
      .s_o    (so[g]),
      .c_o    (co[g]),
      .busy_o (busy[g])
    );
  end

  typedef struct {bit v; int id; int s; int c;} rec_t;
  typedef struct {int req; bit op; int a; int b; int s; int c;} vec_t;

  rec_t hist [MAXC];
  bit   rst_h[MAXC];
  rec_t hold [NL];
  rec_t eout [NL];
  int   ptr, cyc, n_pass, n_total;

  logic [N-1:0] obs_rdy;
  logic         obs_v   [NL];
  int           obs_id  [NL];
  int           obs_s   [NL];
  int           obs_c   [NL];
  logic         obs_busy[NL];

  vec_t vec[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // An op granted at cycle t is discarded by any reset in cycles t+1 .. n-1.
  function automatic bit alive(input int t, input int n);
    for (int k = t + 1; k < n; k++) if (rst_h[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    int g, ag, bg, r, t;
    rec_t e;
    bit eb;
    logic [N-1:0] er;
    @(negedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC);
      $fatal(1);
    end
    g = -1;
    if (!reset && en) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    er = '0;
    hist[cyc] = '{0, 0, 0, 0};
    if (g >= 0) begin
      er = N'(1) << g;
      ag = int'(a[g*W +: W]);
      bg = int'(b[g*W +: W]);
      if (sub[g]) begin
        r = ag - bg;
        hist[cyc] = '{1, g, (r + (1 << W)) % (1 << W), (ag < bg) ? 1 : 0};
      end else begin
        r = ag + bg;
        hist[cyc] = '{1, g, r % (1 << W), r >> W};
      end
    end
    rst_h[cyc] = reset;
    obs_rdy = rdy[0];
    for (int L = 0; L < NL; L++) begin
      e = '{0, hold[L].id, hold[L].s, hold[L].c};
      t = cyc - L;
      if (t >= 0 && hist[t].v && alive(t, cyc)) e = hist[t];
      eb = 1'b0;
      for (int d = 1; d <= L; d++) begin
        t = cyc - d;
        if (t >= 0 && hist[t].v && alive(t, cyc)) eb = 1'b1;
      end
      eout[L] = e;
      chk($sformatf("ready_lat%0d", L), rdy[L], er);
      chk($sformatf("v_lat%0d", L), vo[L], e.v);
      chk($sformatf("id_lat%0d", L), ido[L], e.id);
      chk($sformatf("s_lat%0d", L), so[L], e.s);
      chk($sformatf("c_lat%0d", L), co[L], e.c);
      chk($sformatf("busy_lat%0d", L), busy[L], eb);
      obs_v[L]    = vo[L];
      obs_id[L]   = int'(ido[L]);
      obs_s[L]    = int'(so[L]);
      obs_c[L]    = int'(co[L]);
      obs_busy[L] = busy[L];
    end
    @(posedge clk);
    if (reset) ptr = 0;
    else if (g >= 0) ptr = (g + 1) % N;
    for (int L = 0; L < NL; L++) begin
      if (reset) hold[L] = '{0, 0, 0, 0};
      else if (eout[L].v) hold[L] = eout[L];
    end
    cyc++;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] er;
    n_pass = 0; n_total = 0; ptr = 0; cyc = 0;
    for (int L = 0; L < NL; L++) hold[L] = '{0, 0, 0, 0};
    vec[0] = '{0, 0, 200, 100, 44, 1};
    vec[1] = '{2, 1, 5, 7, 254, 1};
    vec[2] = '{2, 1, 7, 5, 2, 0};
    vec[3] = '{1, 0, 255, 1, 0, 1};
    vec[4] = '{3, 1, 0, 0, 0, 0};
    vec[5] = '{1, 1, 0, 255, 1, 1};
    vec[6] = '{3, 0, 127, 128, 255, 0};
    vec[7] = '{0, 1, 128, 128, 0, 0};

    reset = 1'b1; en = 1'b1; v = '1; sub = '0; a = '0; b = '0;
    @(posedge clk); #1;

    // Reset held with every requester asserting.
    repeat (3) begin
      step();
      chk("t1_ready_in_reset", obs_rdy, 0);
    end
    reset = 1'b0;
    step();
    chk("t1_first_grant_req0", obs_rdy, 4'b0001);
    v = '0;
    repeat (3) step();

    // Isolated single operations against fixed expected sums/differences.
    for (int i = 0; i < 8; i++) begin
      a = '0; b = '0; sub = '0;
      v = N'(1) << vec[i].req;
      sub[vec[i].req] = vec[i].op;
      a[vec[i].req*W +: W] = W'(vec[i].a);
      b[vec[i].req*W +: W] = W'(vec[i].b);
      er = N'(1) << vec[i].req;
      step();
      chk($sformatf("vec%0d_ready", i), obs_rdy, er);
      chk($sformatf("vec%0d_lat0_s", i), obs_s[0], vec[i].s);
      v = '0;
      step();
      chk($sformatf("vec%0d_lat1_v", i), obs_v[1], 1);
      chk($sformatf("vec%0d_lat1_id", i), obs_id[1], vec[i].req);
      chk($sformatf("vec%0d_lat1_s", i), obs_s[1], vec[i].s);
      chk($sformatf("vec%0d_lat1_c", i), obs_c[1], vec[i].c);
      step();
      chk($sformatf("vec%0d_lat2_s", i), obs_s[2], vec[i].s);
      chk($sformatf("vec%0d_lat2_c", i), obs_c[2], vec[i].c);
    end

    // Round robin with all requesters asserting.
    reset = 1'b1; v = '0; step();
    reset = 1'b0; v = '1; sub = '0;
    for (int i = 0; i < 8; i++) begin
      er = N'(1) << (i % N);
      step();
      chk("t4_grant_order", obs_rdy, er);
    end
    v = '0;
    step();
    chk("t4_lat1_last_id", obs_id[1], 3);
    chk("t4_lat2_last_id", obs_id[2], 2);
    step(); step();

    // Enable drop with two ops in flight.
    reset = 1'b1; step();
    reset = 1'b0;
    v = 4'b0001; step();
    v = 4'b0010; step();
    en = 1'b0; v = '1;
    step();
    chk("t5_ready_blocked", obs_rdy, 0);
    chk("t5_first_result_v", obs_v[2], 1);
    chk("t5_first_result_id", obs_id[2], 0);
    step();
    chk("t5_second_result_v", obs_v[2], 1);
    chk("t5_second_result_id", obs_id[2], 1);
    step();
    chk("t5_busy_cleared", obs_busy[2], 0);
    chk("t5_no_extra_result", obs_v[2], 0);
    en = 1'b1; v = '0;

    // Reset while an op is in flight.
    reset = 1'b1; step();
    reset = 1'b0; v = 4'b0100;
    step();
    chk("t6_grant_req2", obs_rdy, 4'b0100);
    reset = 1'b1; v = '0;
    step();
    reset = 1'b0;
    step();
    chk("t6_result_dropped", obs_v[2], 0);
    v = '1;
    step();
    chk("t6_next_grant_req0", obs_rdy, 4'b0001);
    v = '0;
    step(); step();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 7) != 0);
      v     = N'($urandom);
      sub   = N'($urandom);
      a     = $urandom;
      b     = $urandom;
      step();
    end
    reset = 1'b0; en = 1'b1; v = '0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
